// File: rtl/dice_lights_pkg.sv
// Shared types and code constants for the dice / traffic-lights result bus.
package dice_lights_pkg;

    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [CODE_W-1:0] LT_RED     = 3'b100;
    localparam logic [CODE_W-1:0] LT_RED_AMB = 3'b110;
    localparam logic [CODE_W-1:0] LT_GREEN   = 3'b001;
    localparam logic [CODE_W-1:0] LT_AMBER   = 3'b010;

    localparam logic [CODE_W-1:0] DICE_MIN = 3'd1;
    localparam logic [CODE_W-1:0] DICE_MAX = 3'd6;

endpackage

// File: rtl/dice_lights_next.sv
// Combinational successor and legality of a result code in the selected mode.
module dice_lights_next
    import dice_lights_pkg::*;
(
    input  logic              sel,
    input  logic [CODE_W-1:0] code,
    output logic [CODE_W-1:0] next_code,
    output logic              legal
);

    always_comb begin
        next_code = '0;
        legal     = 1'b0;
        if (sel) begin
            case (code)
                LT_RED:     begin next_code = LT_RED_AMB; legal = 1'b1; end
                LT_RED_AMB: begin next_code = LT_GREEN;   legal = 1'b1; end
                LT_GREEN:   begin next_code = LT_AMBER;   legal = 1'b1; end
                LT_AMBER:   begin next_code = LT_RED;     legal = 1'b1; end
                default:    begin next_code = '0;         legal = 1'b0; end
            endcase
        end else if (code >= DICE_MIN && code <= DICE_MAX) begin
            legal     = 1'b1;
            next_code = (code == DICE_MAX) ? DICE_MIN : code + CODE_W'(1);
        end
    end

endmodule

// File: rtl/dice_lights_checker.sv
// Receive-side protocol monitor for the dice / traffic-lights result bus.
// Define DICE_LIGHTS_CAPTURE_EN to build the err_exp / err_got capture registers.
module dice_lights_checker
    import dice_lights_pkg::*;
#(
    parameter int unsigned CNT_W         = 8,
    parameter bit          RESYNC_ON_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic              sel,
    input  logic [CODE_W-1:0] result,
    output logic              locked,
    output logic              err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    output logic [CODE_W-1:0] err_exp,
    output logic [CODE_W-1:0] err_got
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    state_t            state_n;
    logic [CODE_W-1:0] ref_code;
    logic [CODE_W-1:0] ref_n;
    logic              sel_q;
    logic              btn_q;
    logic [CODE_W-1:0] ref_next;
    logic              ref_legal;
    logic [CODE_W-1:0] res_next_unused;
    logic              res_legal;
    logic [CODE_W-1:0] exp_code;
    logic              eff_sync;
    logic              err_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              sticky_n;

    dice_lights_next u_ref_next (
        .sel       (sel),
        .code      (ref_code),
        .next_code (ref_next),
        .legal     (ref_legal)
    );

    dice_lights_next u_res_chk (
        .sel       (sel),
        .code      (result),
        .next_code (res_next_unused),
        .legal     (res_legal)
    );

    // A mode switch (or a reference that is not a code of the current mode) re-enters SYNC rules.
    assign eff_sync = (state == SYNC) || (sel != sel_q) || !ref_legal;
    assign exp_code = (!sel && !btn_q) ? ref_code : ref_next;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SYNC;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and reference update
    always_comb begin
        state_n = state;
        ref_n   = ref_code;
        err_n   = 1'b0;
        if (eff_sync) begin
            if (res_legal) begin
                state_n = TRACK;
                ref_n   = result;
            end else begin
                state_n = SYNC;
                err_n   = 1'b1;
            end
        end else if (result == exp_code) begin
            ref_n = result;
        end else begin
            err_n = 1'b1;
            if (res_legal && RESYNC_ON_ERR) begin
                ref_n = result;
            end else begin
                state_n = SYNC;
            end
        end
    end

    // Next values of the registered error outputs
    always_comb begin
        cnt_n    = err_count;
        sticky_n = err_sticky | err_n;
        if (err_n && (err_count != CNT_MAX)) begin
            cnt_n = err_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_code   <= '0;
            sel_q      <= 1'b0;
            btn_q      <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            ref_code   <= ref_n;
            sel_q      <= sel;
            btn_q      <= button;
            locked     <= (state_n == TRACK);
            err        <= err_n;
            err_sticky <= sticky_n;
            err_count  <= cnt_n;
        end
    end

`ifdef DICE_LIGHTS_CAPTURE_EN
    // Illegal codes seen under SYNC rules have no expectation, recorded as 000.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_exp <= '0;
            err_got <= '0;
        end else if (err_n) begin
            err_exp <= eff_sync ? '0 : exp_code;
            err_got <= result;
        end
    end
`else
    assign err_exp = '0;
    assign err_got = '0;
`endif

endmodule

// File: tb/tb_dice_lights_checker.sv
// Scoreboard bench for dice_lights_checker: default, 2-bit counter and no-resync instances.
module tb_dice_lights_checker;

    logic       clk;
    logic       rst;
    logic       button;
    logic       sel;
    logic [2:0] result;

    logic       lk0, er0, st0, lk1, er1, st1, lk2, er2, st2;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;
    logic [2:0] ex0, gt0, ex1, gt1, ex2, gt2;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit         st;
        logic [2:0] ref_c;
        bit         sel_q;
        bit         btn_q;
        bit         err;
        bit         locked;
        bit         sticky;
        int         cnt;
        logic [2:0] ex;
        logic [2:0] gt;
    } mstate_t;

    mstate_t mdl0, mdl1, mdl2;
    mstate_t sb0[$];
    mstate_t sb1[$];
    mstate_t sb2[$];

    dice_lights_checker u_dut (
        .clk(clk), .rst(rst), .button(button), .sel(sel), .result(result),
        .locked(lk0), .err(er0), .err_sticky(st0), .err_count(cnt0),
        .err_exp(ex0), .err_got(gt0)
    );

    dice_lights_checker #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .button(button), .sel(sel), .result(result),
        .locked(lk1), .err(er1), .err_sticky(st1), .err_count(cnt1),
        .err_exp(ex1), .err_got(gt1)
    );

    dice_lights_checker #(.RESYNC_ON_ERR(1'b0)) u_nrs (
        .clk(clk), .rst(rst), .button(button), .sel(sel), .result(result),
        .locked(lk2), .err(er2), .err_sticky(st2), .err_count(cnt2),
        .err_exp(ex2), .err_got(gt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mstate_t mzero();
        mstate_t z;
        z.st = 0; z.ref_c = 3'd0; z.sel_q = 0; z.btn_q = 0; z.err = 0;
        z.locked = 0; z.sticky = 0; z.cnt = 0; z.ex = 3'd0; z.gt = 3'd0;
        return z;
    endfunction

    // Reference model of one checker instance over a single sampled edge.
    function automatic mstate_t mstep(input mstate_t m, input bit resync, input int cmax,
                                      input bit r, input bit b, input bit s,
                                      input logic [2:0] res);
        mstate_t    n;
        logic [2:0] e;
        bit         lg;
        bit         sy;
        if (!r) return mzero();
        n = m;
        n.err = 0;
        if (s) lg = (res == 3'b100) || (res == 3'b110) || (res == 3'b001) || (res == 3'b010);
        else   lg = (res >= 3'd1) && (res <= 3'd6);
        if (s) begin
            case (m.ref_c)
                3'b100:  e = 3'b110;
                3'b110:  e = 3'b001;
                3'b001:  e = 3'b010;
                3'b010:  e = 3'b100;
                default: e = 3'b000;
            endcase
        end else if (m.btn_q) begin
            e = (m.ref_c == 3'd6) ? 3'd1 : m.ref_c + 3'd1;
        end else begin
            e = m.ref_c;
        end
        sy = !m.st || (s != m.sel_q);
        if (sy) begin
            if (lg) begin n.st = 1; n.ref_c = res; end
            else begin n.st = 0; n.err = 1; e = 3'd0; end
        end else if (res == e) begin
            n.ref_c = res;
        end else begin
            n.err = 1;
            if (lg && resync) n.ref_c = res;
            else n.st = 0;
        end
        if (n.err) begin
            n.sticky = 1;
            if (n.cnt < cmax) n.cnt = n.cnt + 1;
`ifdef DICE_LIGHTS_CAPTURE_EN
            n.ex = e;
            n.gt = res;
`endif
        end
        n.sel_q  = s;
        n.btn_q  = b;
        n.locked = n.st;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_inst(input string nm, input mstate_t e, input logic lk, input logic er,
                            input logic st, input logic [7:0] cnt,
                            input logic [2:0] ex, input logic [2:0] gt);
        chk({nm, ".locked"}, {7'd0, lk}, {7'd0, e.locked});
        chk({nm, ".err"}, {7'd0, er}, {7'd0, e.err});
        chk({nm, ".sticky"}, {7'd0, st}, {7'd0, e.sticky});
        chk({nm, ".count"}, cnt, 8'(e.cnt));
        chk({nm, ".exp"}, {5'd0, ex}, {5'd0, e.ex});
        chk({nm, ".got"}, {5'd0, gt}, {5'd0, e.gt});
    endtask

    task automatic step(input bit r, input bit b, input bit s, input logic [2:0] res);
        @(negedge clk);
        rst = r; button = b; sel = s; result = res;
        mdl0 = mstep(mdl0, 1'b1, 255, r, b, s, res);
        mdl1 = mstep(mdl1, 1'b1, 3,   r, b, s, res);
        mdl2 = mstep(mdl2, 1'b0, 255, r, b, s, res);
        sb0.push_back(mdl0);
        sb1.push_back(mdl1);
        sb2.push_back(mdl2);
        @(posedge clk);
        #1;
        chk_inst("dut", sb0.pop_front(), lk0, er0, st0, cnt0, ex0, gt0);
        chk_inst("sat", sb1.pop_front(), lk1, er1, st1, {6'd0, cnt1}, ex1, gt1);
        chk_inst("nrs", sb2.pop_front(), lk2, er2, st2, cnt2, ex2, gt2);
    endtask

    initial begin
        rst = 1'b0; button = 1'b0; sel = 1'b0; result = 3'd0;
        mdl0 = mzero(); mdl1 = mzero(); mdl2 = mzero();

        // Reset with random inputs
        step(1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
        step(1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
        chk("rst_count", cnt0, 8'd0);
        chk("rst_locked", {7'd0, lk0}, 8'd0);

        // Dice counting with button held
        step(1, 1, 0, 3'd1);
        chk("dice_lock", {7'd0, lk0}, 8'd1);
        step(1, 1, 0, 3'd2); step(1, 1, 0, 3'd3); step(1, 1, 0, 3'd4);
        step(1, 1, 0, 3'd5); step(1, 1, 0, 3'd6); step(1, 1, 0, 3'd1);

        // Dice hold, then an unrequested advance
        step(1, 1, 0, 3'd2); step(1, 0, 0, 3'd3);
        step(1, 0, 0, 3'd3); step(1, 0, 0, 3'd3);
        step(1, 0, 0, 3'd4);
        chk("hold_err", {7'd0, er0}, 8'd1);
        chk("hold_count", cnt0, 8'd1);

        // Lights sequence, illegal code, relock
        step(1, 0, 1, 3'b100); step(1, 0, 1, 3'b110); step(1, 0, 1, 3'b001);
        step(1, 0, 1, 3'b010); step(1, 0, 1, 3'b100);
        step(1, 0, 1, 3'b111);
        chk("lt_illegal_unlock", {7'd0, lk0}, 8'd0);
        step(1, 0, 1, 3'b110);
        chk("lt_relock", {7'd0, lk0}, 8'd1);

        // Mode switch locks on the same sample
        step(1, 0, 0, 3'd4); step(1, 0, 0, 3'd4);
        step(1, 0, 1, 3'b110);
        chk("switch_no_err", {7'd0, er0}, 8'd0);
        chk("switch_locked", {7'd0, lk0}, 8'd1);
        step(1, 0, 1, 3'b001);

        // Illegal dice codes, then expected 5 / got 2
        step(1, 0, 0, 3'd0); step(1, 0, 0, 3'd7);
        step(1, 1, 0, 3'd3); step(1, 1, 0, 3'd4);
        step(1, 0, 0, 3'd2);
        chk("sat_count", {6'd0, cnt1}, 8'd3);
        chk("sat_sticky", {7'd0, st1}, 8'd1);
        chk("dut_count5", cnt0, 8'd5);
`ifdef DICE_LIGHTS_CAPTURE_EN
        chk("cap_exp", {5'd0, ex0}, 8'd5);
        chk("cap_got", {5'd0, gt0}, 8'd2);
`endif

        // Reset mid-stream overrides an illegal sample
        step(0, 1, 0, 3'd7);
        chk("midrst_sticky", {7'd0, st0}, 8'd0);
        chk("midrst_count", cnt0, 8'd0);
        step(1, 0, 0, 3'd5);
        step(1, 0, 0, 3'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
